// File: rtl/serial_capture_pkg.sv
//============================================================================
// Module  : serial_capture_pkg
// Purpose : Shared state encoding, default width and counter-width helper
//           for the serial capture unit.
// Config  : SERIAL_PARITY_EN (the PARITY state is only reached when defined)
// Revision: 1.0 - initial release
//============================================================================
`default_nettype none

package serial_capture_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } cap_state_t;

  localparam int CAP_WIDTH_DEFAULT = 8;

  // Counter width able to hold the values 0..width.
  function automatic int cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/capture_out_buf.sv
//============================================================================
// Module  : capture_out_buf
// Purpose : One-entry holding buffer with Valid/Ready handshake and a sticky
//           overrun flag for words arriving while the buffer is still full.
// Config  : SERIAL_PARITY_EN adds the parity_in input and Parity_err output.
// Revision: 1.0 - initial release
//============================================================================
`default_nettype none

module capture_out_buf #(
  parameter int WIDTH = 8
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             Clear,
  input  logic [WIDTH-1:0] word,
  input  logic             push,
  input  logic             Ready,
`ifdef SERIAL_PARITY_EN
  input  logic             parity_in,
  output logic             Parity_err,
`endif
  output logic [WIDTH-1:0] Data_out,
  output logic             Valid,
  output logic             Overrun
);

  logic [WIDTH-1:0] r_data;
  logic             r_valid;
  logic             r_overrun;
  logic             w_load;
  logic             w_drop;
  logic             w_take;
`ifdef SERIAL_PARITY_EN
  logic             r_perr;
`endif

  // A word may land when the buffer is empty or is being emptied this cycle;
  // otherwise the older word wins and the newcomer is dropped.
  assign w_take = r_valid & Ready;
  assign w_load = push & (~r_valid | Ready);
  assign w_drop = push & r_valid & ~Ready;

  // Buffer contents, valid flag and sticky overrun.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
`ifdef SERIAL_PARITY_EN
      r_perr    <= 1'b0;
`endif
    end else begin
      if (w_load) begin
        r_data  <= word;
        r_valid <= 1'b1;
`ifdef SERIAL_PARITY_EN
        r_perr  <= parity_in;
`endif
      end else if (w_take) begin
        r_valid <= 1'b0;
      end

      if (Clear) begin
        r_overrun <= 1'b0;
      end else if (w_drop) begin
        r_overrun <= 1'b1;
      end
    end
  end

  assign Data_out = r_data;
  assign Valid    = r_valid;
  assign Overrun  = r_overrun;
`ifdef SERIAL_PARITY_EN
  assign Parity_err = r_perr;
`endif

endmodule

`default_nettype wire

// File: rtl/serial_capture_unit.sv
//============================================================================
// Module  : serial_capture_unit
// Purpose : Serial-in / parallel-out receiver. Bits arrive LSB first, one per
//           Shift_En strobe; each WIDTH-bit word is handed to a one-entry
//           Valid/Ready holding buffer.
// Config  : SERIAL_PARITY_EN - expect an even-parity bit after each word and
//           report a mismatch on Parity_err.
// Revision: 1.0 - initial release
//============================================================================
`default_nettype none

module serial_capture_unit
  import serial_capture_pkg::*;
#(
  parameter int WIDTH = CAP_WIDTH_DEFAULT
) (
  input  logic                       Clk,
  input  logic                       Reset_n,
  input  logic                       Clear,
  input  logic                       Shift_In,
  input  logic                       Shift_En,
  input  logic                       Ready,
  output logic [WIDTH-1:0]           Data_out,
  output logic                       Valid,
  output logic                       Overrun,
  output logic                       Busy,
`ifdef SERIAL_PARITY_EN
  output logic                       Parity_err,
`endif
  output logic [cnt_w(WIDTH)-1:0]    Bit_count
);

  localparam int                c_CW   = cnt_w(WIDTH);
  localparam logic [c_CW-1:0]   c_LAST = c_CW'(WIDTH - 1);
  localparam logic [c_CW-1:0]   c_ONE  = c_CW'(1);

  cap_state_t        r_state;
  cap_state_t        w_state_next;
  logic [c_CW-1:0]   r_bit_count;
  logic [c_CW-1:0]   w_count_next;
  logic [WIDTH-1:0]  r_shreg;
  logic [WIDTH-1:0]  w_shreg_next;
  logic [WIDTH-1:0]  w_shifted;
  logic [WIDTH-1:0]  w_word;
  logic              w_push;

  // New bit enters at the MSB and everything moves toward bit 0, so after
  // WIDTH shifts the first bit received sits in bit 0.
  assign w_shifted = WIDTH'({Shift_In, r_shreg} >> 1);

  // State, bit counter and shift register.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state     <= IDLE;
      r_bit_count <= '0;
      r_shreg     <= '0;
    end else begin
      r_state     <= w_state_next;
      r_bit_count <= w_count_next;
      r_shreg     <= w_shreg_next;
    end
  end

  // Next-state logic; Clear outranks an incoming bit.
  always_comb begin
    w_state_next = r_state;
    w_count_next = r_bit_count;
    w_shreg_next = r_shreg;
    w_push       = 1'b0;
    if (Clear) begin
      w_state_next = IDLE;
      w_count_next = '0;
      w_shreg_next = '0;
    end else if (Shift_En) begin
      case (r_state)
`ifdef SERIAL_PARITY_EN
        PARITY: begin
          w_push       = 1'b1;
          w_state_next = IDLE;
          w_count_next = '0;
        end
`endif
        default: begin
          w_shreg_next = w_shifted;
          if (r_bit_count == c_LAST) begin
`ifdef SERIAL_PARITY_EN
            w_state_next = PARITY;
            w_count_next = r_bit_count + c_ONE;
`else
            w_state_next = IDLE;
            w_count_next = '0;
            w_push       = 1'b1;
`endif
          end else begin
            w_state_next = SHIFT;
            w_count_next = r_bit_count + c_ONE;
          end
        end
      endcase
    end
  end

`ifdef SERIAL_PARITY_EN
  // The data word is already complete when the parity bit arrives.
  assign w_word = r_shreg;
`else
  // The word completes on the same edge as its last bit.
  assign w_word = w_shifted;
`endif

  assign Busy      = (r_state != IDLE);
  assign Bit_count = r_bit_count;

  capture_out_buf #(
    .WIDTH      (WIDTH)
  ) u_out_buf (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .Clear      (Clear),
    .word       (w_word),
    .push       (w_push),
    .Ready      (Ready),
`ifdef SERIAL_PARITY_EN
    .parity_in  ((^r_shreg) ^ Shift_In),
    .Parity_err (Parity_err),
`endif
    .Data_out   (Data_out),
    .Valid      (Valid),
    .Overrun    (Overrun)
  );

endmodule

`default_nettype wire

// File: tb/tb_serial_capture_unit.sv
//============================================================================
// Module  : tb_serial_capture_unit
// Purpose : Directed scoreboard bench for serial_capture_unit. Expected words
//           are queued as they are sent; a monitor pops one on every
//           Valid&Ready handshake.
// Config  : SERIAL_PARITY_EN - also exercises the parity bit and Parity_err.
// Revision: 1.0 - initial release
//============================================================================
`default_nettype none

module tb_serial_capture_unit;

  localparam int WIDTH = 8;
  localparam int CW    = $clog2(WIDTH + 1);
`ifdef SERIAL_PARITY_EN
  localparam int NB    = WIDTH + 1;
`else
  localparam int NB    = WIDTH;
`endif

  logic             Clk = 1'b0;
  logic             Reset_n;
  logic             Clear;
  logic             Shift_In;
  logic             Shift_En;
  logic             Ready;
  logic [WIDTH-1:0] Data_out;
  logic             Valid;
  logic             Overrun;
  logic             Busy;
  logic [CW-1:0]    Bit_count;
`ifdef SERIAL_PARITY_EN
  logic             Parity_err;
`endif

  typedef struct packed {
    logic [WIDTH-1:0] d;
    logic             pe;
  } exp_t;

  exp_t q[$];
  exp_t m_e;
  int   n_checks       = 0;
  int   n_pass         = 0;
  int   n_valid_cycles = 0;
  int   base;

  serial_capture_unit #(.WIDTH(WIDTH)) dut (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .Clear      (Clear),
    .Shift_In   (Shift_In),
    .Shift_En   (Shift_En),
    .Ready      (Ready),
    .Data_out   (Data_out),
    .Valid      (Valid),
    .Overrun    (Overrun),
    .Busy       (Busy),
`ifdef SERIAL_PARITY_EN
    .Parity_err (Parity_err),
`endif
    .Bit_count  (Bit_count)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic exp_push(input logic [WIDTH-1:0] d, input logic pe);
    exp_t e;
    e.d  = d;
    e.pe = pe;
    q.push_back(e);
  endtask

  // One strobe: inputs change 1 time unit after a rising edge.
  task automatic send_bit(input logic b);
    Shift_In = b;
    Shift_En = 1'b1;
    @(posedge Clk);
    #1;
    Shift_En = 1'b0;
  endtask

  // Full word LSB first (plus parity bit in parity builds); optionally
  // raise Ready during the final strobe.
  task automatic send_word(input logic [WIDTH-1:0] w, input logic pbit, input logic ready_last);
    for (int i = 0; i < NB; i++) begin
      logic bv;
      bv = pbit;
      if (i < WIDTH) bv = w[i];
      if (i == NB - 1 && ready_last) Ready = 1'b1;
      send_bit(bv);
    end
    if (ready_last) Ready = 1'b0;
  endtask

  task automatic consume();
    Ready = 1'b1;
    @(posedge Clk);
    #1;
    Ready = 1'b0;
  endtask

  // Monitor: count Valid cycles and score every handshake.
  always @(negedge Clk) begin
    if (Reset_n === 1'b1 && Valid === 1'b1) begin
      n_valid_cycles++;
      if (Ready === 1'b1) begin
        check("word_expected", 32'(q.size() != 0), 32'd1);
        if (q.size() != 0) begin
          m_e = q.pop_front();
          check("data_out", 32'(Data_out), 32'(m_e.d));
`ifdef SERIAL_PARITY_EN
          check("parity_err", 32'(Parity_err), 32'(m_e.pe));
`endif
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    Reset_n  = 1'b0;
    Clear    = 1'b0;
    Shift_In = 1'b0;
    Shift_En = 1'b0;
    Ready    = 1'b0;
    #1;
    check("rst_data",  32'(Data_out),  32'h0);
    check("rst_valid", 32'(Valid),     32'h0);
    check("rst_ovr",   32'(Overrun),   32'h0);
    check("rst_busy",  32'(Busy),      32'h0);
    check("rst_count", 32'(Bit_count), 32'h0);
    repeat (2) @(posedge Clk);
    #1;
    Reset_n = 1'b1;

    // 1: asynchronous reset mid-word, then A5
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
    check("t1_count3", 32'(Bit_count), 32'd3);
    check("t1_busy",   32'(Busy),      32'd1);
    #2;
    Reset_n = 1'b0;
    #1;
    check("t1_async_busy",  32'(Busy),      32'd0);
    check("t1_async_count", 32'(Bit_count), 32'd0);
    @(posedge Clk);
    #1;
    Reset_n = 1'b1;
    exp_push(8'hA5, 1'b0);
    send_word(8'hA5, ^8'hA5, 1'b0);
    check("t1_valid", 32'(Valid),    32'd1);
    check("t1_data",  32'(Data_out), 32'hA5);
    consume();
    check("t1_valid_drop", 32'(Valid), 32'd0);

    // 2: overrun while held, then Clear
    exp_push(8'h3C, 1'b0);
    send_word(8'h3C, ^8'h3C, 1'b0);
    send_word(8'h81, ^8'h81, 1'b0);
    check("t2_data_kept", 32'(Data_out), 32'h3C);
    check("t2_overrun",   32'(Overrun),  32'd1);
    Clear = 1'b1;
    @(posedge Clk);
    #1;
    Clear = 1'b0;
    check("t2_ovr_clr",    32'(Overrun),  32'd0);
    check("t2_valid_kept", 32'(Valid),    32'd1);
    check("t2_data_clr",   32'(Data_out), 32'h3C);
    consume();

    // 3: back-to-back words with Ready held high
    Ready = 1'b1;
    base  = n_valid_cycles;
    exp_push(8'h01, 1'b0);
    exp_push(8'hFF, 1'b0);
    exp_push(8'h80, 1'b0);
    send_word(8'h01, ^8'h01, 1'b0);
    send_word(8'hFF, ^8'hFF, 1'b0);
    send_word(8'h80, ^8'h80, 1'b0);
    @(posedge Clk);
    #1;
    Ready = 1'b0;
    check("t3_valid_cycles", 32'(n_valid_cycles - base), 32'd3);
    check("t3_overrun",      32'(Overrun),               32'd0);
    check("t3_valid_end",    32'(Valid),                 32'd0);

    // 4: handshake on the completing edge
    exp_push(8'h12, 1'b0);
    send_word(8'h12, ^8'h12, 1'b0);
    exp_push(8'h5A, 1'b0);
    send_word(8'h5A, ^8'h5A, 1'b1);
    check("t4_valid",   32'(Valid),    32'd1);
    check("t4_data",    32'(Data_out), 32'h5A);
    check("t4_overrun", 32'(Overrun),  32'd0);
    consume();

    // 5: gapped strobes for C3
    exp_push(8'hC3, 1'b0);
    for (int i = 0; i < NB; i++) begin
      logic [WIDTH-1:0] w;
      logic bv;
      w  = 8'hC3;
      bv = ^w;
      if (i < WIDTH) bv = w[i];
      check("t5_count", 32'(Bit_count), 32'(i));
      send_bit(bv);
      repeat (5) @(posedge Clk);
      #1;
      if (i < NB - 1) check("t5_busy", 32'(Busy), 32'd1);
    end
    check("t5_count_end", 32'(Bit_count), 32'd0);
    check("t5_busy_end",  32'(Busy),      32'd0);
    check("t5_data",      32'(Data_out),  32'hC3);
    consume();

    // Clear together with Shift_En after 4 bits
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
    check("t5_pre_clr_count", 32'(Bit_count), 32'd4);
    Clear    = 1'b1;
    Shift_In = 1'b1;
    Shift_En = 1'b1;
    @(posedge Clk);
    #1;
    Clear    = 1'b0;
    Shift_En = 1'b0;
    check("t5_clr_count", 32'(Bit_count), 32'd0);
    check("t5_clr_busy",  32'(Busy),      32'd0);
    check("t5_clr_valid", 32'(Valid),     32'd0);
    exp_push(8'h96, 1'b0);
    send_word(8'h96, ^8'h96, 1'b0);
    check("t5_after_clr", 32'(Data_out), 32'h96);
    consume();

`ifdef SERIAL_PARITY_EN
    // 6: parity bit good, then bad
    for (int k = 0; k < 2; k++) begin
      logic [WIDTH-1:0] w;
      w = 8'hA5;
      for (int i = 0; i < WIDTH; i++) send_bit(w[i]);
      check("t6_valid_pre", 32'(Valid),     32'd0);
      check("t6_busy_par",  32'(Busy),      32'd1);
      check("t6_count_par", 32'(Bit_count), 32'd8);
      exp_push(8'hA5, (k == 1));
      send_bit(k == 1);
      check("t6_valid",     32'(Valid),      32'd1);
      check("t6_perr_now",  32'(Parity_err), 32'(k));
      consume();
    end
`endif

    repeat (2) @(posedge Clk);
    #1;
    check("queue_drained", 32'(q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/serial_capture_unit.md
Name: serial_capture_unit

Overview:
Serial-in, parallel-out receiver. It is the far end of the multiplier datapath's shift register, which shifts right and emits its LSB first.
- Samples one bit per Shift_En strobe and assembles WIDTH bits into a word.
- Presents each completed word on a one-entry holding buffer with a Valid/Ready handshake.
- Sits between a shifting source, such as the register unit's serial output, and any parallel consumer: display, checker or next datapath stage.

Parameters:
WIDTH, 8, number of data bits per word; legal range 2..32.

Ports:
Clk  input  1  system clock; all state updates on rising edge.
Reset_n  input  1  asynchronous active-low reset.
Clear  input  1  synchronous; discards the partial word and clears Overrun.
Shift_In  input  1  serial data bit, sampled when Shift_En=1.
Shift_En  input  1  bit strobe; one bit accepted per cycle in which it is high.
Ready  input  1  consumer accepts Data_out this cycle when Valid=1.
Data_out  output  WIDTH  completed word; first bit received sits in bit 0.
Valid  output  1  Data_out holds an unconsumed word.
Overrun  output  1  sticky; a completed word was dropped.
Busy  output  1  a partial word is in progress.
Bit_count  output  $clog2(WIDTH+1)  bits received for the current word.
Parity_err  output  1  present only with the optional feature.

Behaviour:
Reset (Reset_n=0, asynchronous):
- Shift register = 0, Bit_count = 0, state = IDLE.
- Data_out = 0, Valid = 0, Overrun = 0, Busy = 0, Parity_err = 0.

Shift path:
- On each accepted bit: shreg <= {Shift_In, shreg[WIDTH-1:1]}, and Bit_count increments.
- After WIDTH shifts the word appears in the source's original bit order. LSB first is required.

State machine (states IDLE, SHIFT):
- IDLE -> SHIFT on the first Shift_En.
- SHIFT -> IDLE on the cycle in which the WIDTH-th bit is accepted.
- On that same edge, Bit_count returns to 0 and the completed word is offered to the holding buffer.
- Busy = (state == SHIFT).

Holding buffer:
- Latency: Data_out and Valid update on the same edge that accepts the last bit, so Valid is visible in the following cycle.
- Handshake: Valid stays high and Data_out stays stable until a cycle with Valid=1 and Ready=1. Valid drops on the next edge unless a new word lands on that same edge.
- Ready while Valid=0 has no effect.

Boundary cases:
- Word completes while Valid=1 and Ready=0: the new word is dropped, the old word is kept, and Overrun is set. Overrun stays set until Clear or reset.
- Word completes in the same cycle as a handshake: the new word is loaded and Valid stays 1. Overrun is not set.
- Back-to-back words (Shift_En held high continuously) are legal. With Ready tied high, every WIDTH cycles produces exactly one word.
- Clear has priority over Shift_En in the same cycle. Clear resets the partial word, Bit_count, state and Overrun. It does not affect Data_out or Valid.
- Shift_En low for any number of cycles mid-word: the partial word is held indefinitely.
- Reset asserted mid-word: everything returns to reset values immediately, with no wait for the clock.

Optional Feature:
Macro: SERIAL_PARITY_EN.

When defined:
- Adds a PARITY state after the WIDTH-th data bit. The next accepted bit is an even-parity bit.
- The word is offered to the buffer only after the parity bit is accepted, so latency is WIDTH+1 strobes.
- Parity_err is registered alongside Data_out. It is 1 when XOR(word, parity bit) = 1.
- Parity_err follows the same Valid/handshake rules as Data_out.
- Busy covers the PARITY state. Bit_count counts 0..WIDTH.

When undefined:
- No PARITY state and no Parity_err port. Exactly WIDTH strobes make one word.

Decomposition:
Package serial_capture_pkg:
- State enum cap_state_t {IDLE, SHIFT, PARITY}.
- Constant CAP_WIDTH_DEFAULT = 8.
- Function cnt_w(width) returning $clog2(width+1).

Sub-module capture_out_buf:
- Holds Data_out, Valid, Overrun and Parity_err.
- Inputs: word, push, Ready, Clear.
- Keeps the handshake and overrun rules separate from the shift/count FSM.

Test Plan:
1. Reset_n=0 mid-word after 3 bits -> all outputs 0 immediately. Then bits 1,0,1,0,0,1,0,1 -> Data_out=8'hA5, Valid=1 one cycle after the 8th strobe.
2. Ready=0 with 8'h3C captured, then 8'h81 fully shifted -> Data_out stays 8'h3C, Overrun=1. Pulse Clear -> Overrun=0 while Valid stays 1.
3. Ready=1 and Shift_En continuous for 24 cycles carrying 8'h01, 8'hFF, 8'h80 -> three Valid pulses, each 1 cycle wide, with matching Data_out and Overrun=0.
4. Handshake on the same edge that completes 8'h5A while 8'h12 is held -> Data_out becomes 8'h5A, Valid never drops, Overrun=0.
5. Shift_En gapped (bit, 5 idle cycles, bit, ...) for 8'hC3 -> Bit_count steps 0..7 then returns to 0, Busy=1 throughout, Data_out=8'hC3. Clear asserted together with Shift_En after 4 bits -> Bit_count=0, Busy=0.
6. With SERIAL_PARITY_EN: 8'hA5 plus parity bit 0 -> Parity_err=0. 8'hA5 plus parity bit 1 -> Parity_err=1. Valid appears only after the 9th strobe in both cases.
